// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the vending machine money-out path: coin values,
// coin_type encoding and the dispenser state encoding.
package change_dispenser_pkg;

    localparam logic [10:0] COIN_500       = 11'd500;
    localparam logic [10:0] COIN_100       = 11'd100;
    localparam int          MAX_AMOUNT_WON = 1000;

    typedef enum logic {
        COIN_T100 = 1'b0,
        COIN_T500 = 1'b1
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAIL    = 3'd4
    } disp_state_t;

endpackage

// File: rtl/coin_inventory.sv
// 500-won and 100-won coin stock: saturating up/down counters with restock
// inputs and one-coin decrement strobes from the dispenser.
module coin_inventory #(
    parameter int CNT_W    = 8,
    parameter int INIT_500 = 20,
    parameter int INIT_100 = 50
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             restock_500,
    input  logic             restock_100,
    input  logic             dec_500,
    input  logic             dec_100,
    output logic [CNT_W-1:0] cnt_500,
    output logic [CNT_W-1:0] cnt_100
);

    // Restock and decrement together cancel; the count sticks at full scale.
    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec && cnt != '1)
            r = cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            r = cnt - CNT_W'(1);
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_500 <= CNT_W'(INIT_500);
            cnt_100 <= CNT_W'(INIT_100);
        end else begin
            cnt_500 <= step(cnt_500, restock_500, dec_500);
            cnt_100 <= step(cnt_100, restock_100, dec_100);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change/refund request one coin at a time (500s first, then 100s)
// over a valid/ack handshake to the hopper, reporting any unpaid shortfall.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W      = 11,
    parameter int MAX_AMOUNT = MAX_AMOUNT_WON,
    parameter int CNT_W      = 8,
    parameter int INIT_500   = 20,
    parameter int INIT_100   = 50
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic             coin_valid,
    output logic             coin_type,
    input  logic             coin_ack,
    output logic             done,
    output logic             fail,
    output logic [AMT_W-1:0] shortfall,
    input  logic             restock_500,
    input  logic             restock_100,
    output logic [CNT_W-1:0] cnt_500,
    output logic [CNT_W-1:0] cnt_100
);

    localparam logic [AMT_W-1:0] V500 = AMT_W'(COIN_500);
    localparam logic [AMT_W-1:0] V100 = AMT_W'(COIN_100);

    disp_state_t      state, state_next;
    logic [AMT_W-1:0] remaining;
    coin_t            coin_sel;
    logic             legal, pick_500, pick_100, dec_500, dec_100;

    // Legal amounts are whole multiples of 100 won up to MAX_AMOUNT.
    function automatic logic is_legal(input logic [AMT_W-1:0] amt);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k <= MAX_AMOUNT / 100; k++)
            if (amt == AMT_W'(k * 100))
                ok = 1'b1;
        return ok;
    endfunction

    assign legal    = is_legal(req_amount);
    assign pick_500 = (remaining >= V500) && (cnt_500 != '0);
    assign pick_100 = (remaining >= V100) && (cnt_100 != '0);
    assign dec_500  = (state == ST_PRESENT) && coin_ack && (coin_sel == COIN_T500);
    assign dec_100  = (state == ST_PRESENT) && coin_ack && (coin_sel == COIN_T100);

    assign req_ready  = (state == ST_IDLE);
    assign coin_valid = (state == ST_PRESENT);
    assign done       = (state == ST_DONE);
    assign fail       = (state == ST_FAIL);
    assign coin_type  = coin_sel;

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (req_valid) state_next = legal ? ST_SELECT : ST_FAIL;
            ST_SELECT: begin
                if (remaining == '0)           state_next = ST_DONE;
                else if (pick_500 || pick_100) state_next = ST_PRESENT;
                else                           state_next = ST_FAIL;
            end
            ST_PRESENT: if (coin_ack) state_next = ST_SELECT;
            ST_DONE:    state_next = ST_IDLE;
            ST_FAIL:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // remaining cannot underflow: a coin is only chosen when it fits.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
            shortfall <= '0;
            coin_sel  <= COIN_T100;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    if (legal) begin
                        remaining <= req_amount;
                        shortfall <= '0;
                    end else begin
                        shortfall <= req_amount;
                    end
                end
                ST_SELECT: if (remaining != '0) begin
                    if (pick_500)      coin_sel  <= COIN_T500;
                    else if (pick_100) coin_sel  <= COIN_T100;
                    else               shortfall <= remaining;
                end
                ST_PRESENT: if (coin_ack)
                    remaining <= remaining - ((coin_sel == COIN_T500) ? V500 : V100);
                default: ;
            endcase
        end
    end

    coin_inventory #(
        .CNT_W   (CNT_W),
        .INIT_500(INIT_500),
        .INIT_100(INIT_100)
    ) u_inventory (
        .clock      (clock),
        .reset      (reset),
        .restock_500(restock_500),
        .restock_100(restock_100),
        .dec_500    (dec_500),
        .dec_100    (dec_100),
        .cnt_500    (cnt_500),
        .cnt_100    (cnt_100)
    );

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a transaction-level payout model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_change_dispenser;

    localparam int AMT_W = 11, CNT_W = 8, INIT_500 = 20, INIT_100 = 50;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount = '0;
    logic             coin_valid, coin_type;
    logic             coin_ack = 1'b0;
    logic             done, fail;
    logic [AMT_W-1:0] shortfall;
    logic             restock_500 = 1'b0, restock_100 = 1'b0;
    logic [CNT_W-1:0] cnt_500, cnt_100;

    change_dispenser #(.AMT_W(AMT_W), .MAX_AMOUNT(1000), .CNT_W(CNT_W),
                       .INIT_500(INIT_500), .INIT_100(INIT_100)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_amount(req_amount), .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_ack(coin_ack), .done(done), .fail(fail), .shortfall(shortfall),
        .restock_500(restock_500), .restock_100(restock_100),
        .cnt_500(cnt_500), .cnt_100(cnt_100));

    always #5 clock = ~clock;

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // A request is planned greedily at accept time: the list of coins, then
    // done or a fail with the unpaid rest. Timing: first event 2 cycles after
    // accept (1 for an illegal amount), each following event 2 cycles after an ack.
    bit m_on = 0, m_busy = 0, m_end_fail = 0;
    bit m_q[$];
    int m5, m1, m_short, m_plan_short, m_evt, cyc = 0;

    function automatic void plan(input int amt);
        int r, c5, c1;
        m_q.delete();
        r = amt; c5 = m5; c1 = m1;
        while (r > 0) begin
            if (r >= 500 && c5 > 0)      begin m_q.push_back(1'b1); c5--; r -= 500; end
            else if (r >= 100 && c1 > 0) begin m_q.push_back(1'b0); c1--; r -= 100; end
            else break;
        end
        m_end_fail   = (r != 0);
        m_plan_short = r;
    endfunction

    always @(negedge clock) begin
        int e_ready, e_cv, e_ct, e_done, e_fail, amt;
        if (reset) begin
            m_on = 1; m_busy = 0; m5 = INIT_500; m1 = INIT_100; m_short = 0;
            m_q.delete();
        end else if (m_on) begin
            e_ready = !m_busy; e_cv = 0; e_ct = 0; e_done = 0; e_fail = 0;
            if (m_busy && cyc >= m_evt) begin
                if (m_q.size() > 0) begin e_cv = 1; e_ct = int'(m_q[0]); end
                else if (m_end_fail) begin e_fail = 1; m_short = m_plan_short; end
                else e_done = 1;
            end
            chk("req_ready", int'(req_ready), e_ready);
            chk("coin_valid", int'(coin_valid), e_cv);
            if (e_cv != 0) chk("coin_type", int'(coin_type), e_ct);
            chk("done", int'(done), e_done);
            chk("fail", int'(fail), e_fail);
            chk("shortfall", int'(shortfall), m_short);
            chk("cnt_500", int'(cnt_500), m5);
            chk("cnt_100", int'(cnt_100), m1);
            // advance the model with this cycle's inputs
            if (e_cv != 0 && coin_ack) begin
                if (e_ct != 0) m5--; else m1--;
                void'(m_q.pop_front());
                m_evt = cyc + 2;
            end
            if (e_done != 0 || e_fail != 0) m_busy = 0;
            m5 += int'(restock_500); if (m5 > 255) m5 = 255;
            m1 += int'(restock_100); if (m1 > 255) m1 = 255;
            if (e_ready != 0 && req_valid) begin
                amt = int'(req_amount);
                m_busy = 1;
                if (amt % 100 == 0 && amt <= 1000) begin
                    plan(amt); m_short = 0; m_evt = cyc + 2;
                end else begin
                    m_q.delete(); m_end_fail = 1; m_plan_short = amt; m_evt = cyc + 1;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clock); #1;
    endtask

    task automatic send_req(input int amt);
        int g = 0;
        while (!req_ready && g < 100) begin next_cyc(); g++; end
        if (g >= 100) chk("req_ready_timeout", g, 0);
        req_valid = 1'b1; req_amount = AMT_W'(amt);
        next_cyc();
        req_valid = 1'b0;
    endtask

    task automatic serve(input int delay, input bit rs100,
                         output int ncoins, output bit got_done, output bit got_fail);
        int g = 0;
        ncoins = 0; got_done = 0; got_fail = 0;
        while (!got_done && !got_fail && g < 300) begin
            if (done) got_done = 1;
            else if (fail) got_fail = 1;
            else begin
                if (coin_valid) begin
                    repeat (delay) next_cyc();
                    coin_ack = 1'b1; restock_100 = rs100;
                    next_cyc();
                    coin_ack = 1'b0; restock_100 = 1'b0;
                    ncoins++;
                end else begin
                    next_cyc();
                end
                g++;
            end
        end
        if (g >= 300) chk("serve_timeout", g, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  d, f;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_cnt_500", int'(cnt_500), 20);
        chk("rst_cnt_100", int'(cnt_100), 50);

        // 700 won with full stock: 500, 100, 100
        send_req(700);
        serve(1, 1'b0, n, d, f);
        chk("t1_coins", n, 3);
        chk("t1_done", int'(d), 1);
        next_cyc();
        chk("t1_cnt_500", int'(cnt_500), 19);
        chk("t1_cnt_100", int'(cnt_100), 48);

        // zero request: done, no coins
        send_req(0);
        serve(0, 1'b0, n, d, f);
        chk("t2_coins", n, 0);
        chk("t2_done", int'(d), 1);
        chk("t2_fail", int'(f), 0);
        next_cyc();

        // illegal amounts
        send_req(250);
        serve(0, 1'b0, n, d, f);
        chk("t3a_fail", int'(f), 1);
        chk("t3a_short", int'(shortfall), 250);
        next_cyc();
        send_req(1100);
        serve(0, 1'b0, n, d, f);
        chk("t3b_fail", int'(f), 1);
        chk("t3b_coins", n, 0);
        chk("t3b_short", int'(shortfall), 1100);
        next_cyc();
        chk("t3_cnt_500", int'(cnt_500), 19);
        chk("t3_cnt_100", int'(cnt_100), 48);

        // slow hopper, restock_100 in the ack cycle of a 100 coin
        send_req(100);
        serve(10, 1'b1, n, d, f);
        chk("t5_coins", n, 1);
        chk("t5_done", int'(d), 1);
        next_cyc();
        chk("t5_cnt_100", int'(cnt_100), 48);

        // reset while a coin is presented
        send_req(900);
        n = 0;
        while (!coin_valid && n < 20) begin next_cyc(); n++; end
        chk("t6_present", int'(coin_valid), 1);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        chk("t6_ready", int'(req_ready), 1);
        chk("t6_cv", int'(coin_valid), 0);
        chk("t6_cnt_500", int'(cnt_500), 20);
        chk("t6_cnt_100", int'(cnt_100), 50);
        send_req(100);
        serve(0, 1'b0, n, d, f);
        chk("t6_coins", n, 1);
        chk("t6_done", int'(d), 1);
        next_cyc();

        // drain to 0 x 500 and 1 x 100 (start 20/49)
        for (int i = 0; i < 14; i++) begin
            send_req(1000);
            serve(0, 1'b0, n, d, f);
            next_cyc();
        end
        send_req(800);
        serve(0, 1'b0, n, d, f);
        next_cyc();
        chk("t4_pre_500", int'(cnt_500), 0);
        chk("t4_pre_100", int'(cnt_100), 1);
        send_req(600);
        serve(0, 1'b0, n, d, f);
        chk("t4_coins", n, 1);
        chk("t4_fail", int'(f), 1);
        chk("t4_short", int'(shortfall), 500);
        next_cyc();
        chk("t4_cnt_100", int'(cnt_100), 0);

        repeat (3) next_cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
